// File: rtl/venc_frame_ctrl.sv
// venc_frame_ctrl: frame sequencer feeding bytes MSB-first into a convolutional encoder.
// Optional zero-tail termination is enabled by defining VENC_TAIL_EN.
module venc_frame_ctrl #(
    parameter int FRAME_BYTES = 4,
    parameter int BIT_PERIOD  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       enc_in,
    output logic       enc_shift,
    output logic       enc_clear,
    output logic       busy,
    output logic       done,
    output logic       underflow
);
`ifdef VENC_TAIL_EN
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SHIFT, TAIL, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SHIFT, DONE} state_t;
`endif
    localparam logic [3:0] PH_LAST = 4'(BIT_PERIOD - 1);
    localparam logic [7:0] NBYTES  = 8'(FRAME_BYTES);
    localparam logic       SHIFT1  = (BIT_PERIOD == 1);
    state_t     state;
    logic [3:0] phase;
    logic [2:0] bitcnt;
    logic [7:0] bytecnt;
    logic [7:0] sreg;
    // frame sequencer; every output is registered and set for the cycle the next state occupies
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            bitcnt     <= '0;
            bytecnt    <= '0;
            sreg       <= '0;
            byte_ready <= 1'b0;
            enc_in     <= 1'b0;
            enc_shift  <= 1'b0;
            enc_clear  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CLEAR;
                        enc_clear <= 1'b1;
                        busy      <= 1'b1;
                        underflow <= 1'b0;
                        bytecnt   <= '0;
                        bitcnt    <= '0;
                        phase     <= '0;
                    end
                end
                CLEAR: begin
                    state      <= LOAD;
                    enc_clear  <= 1'b0;
                    byte_ready <= 1'b1;
                end
                LOAD: begin
                    if (byte_valid) begin
                        state      <= SHIFT;
                        sreg       <= byte_data;
                        bytecnt    <= bytecnt + 8'd1;
                        phase      <= '0;
                        bitcnt     <= '0;
                        byte_ready <= 1'b0;
                        enc_in     <= byte_data[7];
                        enc_shift  <= SHIFT1;
                    end else if (bytecnt != 8'd0) begin
                        underflow <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (phase == PH_LAST) begin
                        sreg  <= {sreg[6:0], 1'b0};
                        phase <= '0;
                        if (bitcnt == 3'd7) begin
                            bitcnt <= '0;
                            enc_in <= 1'b0;
                            if (bytecnt < NBYTES) begin
                                state      <= LOAD;
                                byte_ready <= 1'b1;
                                enc_shift  <= 1'b0;
                            end else begin
`ifdef VENC_TAIL_EN
                                state     <= TAIL;
                                enc_shift <= SHIFT1;
`else
                                state     <= DONE;
                                done      <= 1'b1;
                                enc_shift <= 1'b0;
`endif
                            end
                        end else begin
                            bitcnt    <= bitcnt + 3'd1;
                            enc_in    <= sreg[6];
                            enc_shift <= SHIFT1;
                        end
                    end else begin
                        phase     <= phase + 4'd1;
                        enc_shift <= (phase + 4'd1 == PH_LAST);
                    end
                end
`ifdef VENC_TAIL_EN
                TAIL: begin
                    if (phase == PH_LAST) begin
                        phase <= '0;
                        if (bitcnt == 3'd1) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            bitcnt    <= '0;
                            enc_shift <= 1'b0;
                        end else begin
                            bitcnt    <= bitcnt + 3'd1;
                            enc_shift <= SHIFT1;
                        end
                    end else begin
                        phase     <= phase + 4'd1;
                        enc_shift <= (phase + 4'd1 == PH_LAST);
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/venc_frame_ctrl.md
VENC_FRAME_CTRL -- requirements
Module: venc_frame_ctrl

Interface
REQ-001 Parameter: FRAME_BYTES, 4, data bytes per encoded frame (legal 1..255).
REQ-002 Parameter: BIT_PERIOD, 2, clock cycles per encoder bit; 2 matches the encoder's two-symbol serial output (legal 1..15).
REQ-003 Port: clock  in  1  single system clock; all state on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 Port: start  in  1  one-cycle request to begin a frame.
REQ-006 Port: byte_data  in  8  frame data byte, transmitted MSB first.
REQ-007 Port: byte_valid  in  1  byte_data valid.
REQ-008 Port: byte_ready  out  1  controller accepts byte_data this cycle.
REQ-009 Port: enc_in  out  1  data bit to encoder input.
REQ-010 Port: enc_shift  out  1  one-cycle strobe: encoder shifts enc_in into its state.
REQ-011 Port: enc_clear  out  1  one-cycle strobe: encoder state cleared to 000.
REQ-012 Port: busy  out  1  frame in progress (any state but IDLE).
REQ-013 Port: done  out  1  one-cycle pulse at frame end.
REQ-014 Port: underflow  out  1  sticky: a data byte was late mid-frame.

Function
REQ-015 FSM states IDLE, CLEAR, LOAD, SHIFT, TAIL, DONE shall be implemented as listed below.
REQ-016 IDLE: busy=0, byte_ready=0; start=1 -> CLEAR, clear underflow, byte counter=0.
REQ-017 CLEAR: enc_clear=1 for exactly one cycle -> LOAD.
REQ-018 LOAD: byte_ready=1; byte_valid&&byte_ready captures byte into 8-bit shift register, increments byte counter -> SHIFT; else stay.
REQ-019 LOAD: each cycle waiting with byte_valid=0 when byte counter>0 sets underflow; no enc_shift issued while waiting.
REQ-020 SHIFT: enc_in = current MSB of shift register, held stable for a full bit period; phase counter runs 0..BIT_PERIOD-1, enc_shift=1 only at phase BIT_PERIOD-1, then register shifts left.
REQ-021 After 8th enc_shift of a byte: byte counter<FRAME_BYTES -> LOAD; else -> TAIL (macro set) or DONE.
REQ-022 TAIL: enc_in=0; two bit periods, two enc_shift strobes -> DONE.
REQ-023 DONE: done=1 one cycle -> IDLE; start in DONE ignored.
REQ-024 start while busy=1 ignored; no restart, no error.
REQ-025 Total enc_shift per frame: 8*FRAME_BYTES + 2 (macro set) or 8*FRAME_BYTES (macro unset).
REQ-026 Latency with byte_valid=1: start at cycle 0 -> enc_clear cycle 1 -> byte accepted cycle 2 -> first enc_shift cycle 2+BIT_PERIOD.
REQ-027 Outside SHIFT/TAIL: enc_in=0, enc_shift=0.
REQ-028 BIT_PERIOD=1: enc_shift high every SHIFT/TAIL cycle.

Reset
REQ-029 reset=1 forces IDLE, byte_ready, enc_in, enc_shift, enc_clear, busy, done, underflow, counters, shift register to 0, asynchronously.
REQ-030 Reset mid-frame abandons the frame; no done pulse; next start begins a fresh frame with enc_clear.

Configuration
REQ-031 Macro VENC_TAIL_EN defined: two zero tail bits terminate trellis to state 00 (TAIL state present).
REQ-032 VENC_TAIL_EN undefined: TAIL state absent; SHIFT -> DONE directly after last data bit.

Verification
REQ-033 FRAME_BYTES=1, BIT_PERIOD=2, macro set, byte 0xA5 valid constant, start cycle 0 -> enc_clear cycle 1, enc_shift at cycles 4,6,...,22 (10 strobes), enc_in bits 1,0,1,0,0,1,0,1,0,0, done cycle 23.
REQ-034 Same, macro unset -> 8 strobes (cycles 4..18), done cycle 19, busy low cycle 20.
REQ-035 FRAME_BYTES=2, second byte withheld 5 cycles -> no enc_shift during gap, underflow=1 until next start, frame completes with 18 strobes.
REQ-036 start pulsed at cycle 10 of active frame -> ignored, strobe count and done timing unchanged.
REQ-037 reset asserted mid-SHIFT -> all outputs 0 same cycle, no done; new start -> enc_clear then full frame.
REQ-038 BIT_PERIOD=1, FRAME_BYTES=1, byte 0xFF, macro set -> enc_shift high cycles 3..12, enc_in 1x8 then 0x2, done cycle 13.
